// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

    // Default data width of the register file.
    localparam int unsigned XLEN_DEFAULT = 16;

    // Architectural index of the register that may be hardwired to zero.
    localparam int unsigned REG_ZERO = 0;

    // Address width for n registers; at least one bit even for tiny files.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for in-flight producers.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   clr_en, clr_addr     legal writeback: clear busy[clr_addr]
//   set_en, set_addr     issue: mark busy[set_addr]
//   flush                clear every busy bit
//   busy_vec             registered busy bits, bit i = register i
// Priority within one edge: flush, then clear, then set (set wins).
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int unsigned NREGS   = 16,
    parameter  bit          ZERO_R0 = 1'b1,
    localparam int unsigned AW      = addr_width(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    input  logic             flush,
    output logic [NREGS-1:0] busy_vec
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic             w_set_ok;
    logic             w_clr_ok;

    // Out-of-range addresses and r0 (when hardwired) never change state.
    assign w_set_ok = set_en && (32'(set_addr) < NREGS)
                      && !(ZERO_R0 && (set_addr == AW'(REG_ZERO)));
    assign w_clr_ok = clr_en && (32'(clr_addr) < NREGS);

    // Next busy state: flush, then clear, then set so a new producer wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end
        if (w_clr_ok) begin
            w_busy_nxt[clr_addr] = 1'b0;
        end
        if (w_set_ok) begin
            w_busy_nxt[set_addr] = 1'b1;
        end
    end

    // Busy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_vec = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with scoreboard and write-to-read bypass.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ra1/ra2              read addresses; rd1/rd2 combinational read data
//   rbusy1/rbusy2        pending-producer flag for ra1/ra2
//   we3, wa3, wd3        writeback port; a legal write also clears busy
//   sb_set, sb_addr      issue: mark destination busy
//   sb_flush             clear every busy bit
//   busy_vec             registered busy bits
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN    = XLEN_DEFAULT,
    parameter  int unsigned NREGS   = 16,
    parameter  bit          ZERO_R0 = 1'b1,
    parameter  bit          BYPASS  = 1'b1,
    localparam int unsigned AW      = addr_width(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [XLEN-1:0]  rd1,
    output logic [XLEN-1:0]  rd2,
    output logic             rbusy1,
    output logic             rbusy2,
    input  logic             we3,
    input  logic [AW-1:0]    wa3,
    input  logic [XLEN-1:0]  wd3,
    input  logic             sb_set,
    input  logic [AW-1:0]    sb_addr,
    input  logic             sb_flush,
    output logic [NREGS-1:0] busy_vec
);

    typedef logic [AW-1:0] reg_addr_t;

    logic [XLEN-1:0]  r_regs [NREGS];
    logic             w_wr_legal;
    logic [NREGS-1:0] w_busy;
    reg_addr_t        w_ra    [2];
    logic [XLEN-1:0]  w_rd    [2];
    logic             w_rbusy [2];

    assign w_wr_legal = we3 && (32'(wa3) < NREGS)
                        && !(ZERO_R0 && (wa3 == reg_addr_t'(REG_ZERO)));

    // Data array; r0 is never written when hardwired to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_legal) begin
            r_regs[wa3] <= wd3;
        end
    end

    regfile_scoreboard #(
        .NREGS   (NREGS),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_en   (w_wr_legal),
        .clr_addr (wa3),
        .set_en   (sb_set),
        .set_addr (sb_addr),
        .flush    (sb_flush),
        .busy_vec (w_busy)
    );

    assign busy_vec = w_busy;
    assign w_ra[0]  = ra1;
    assign w_ra[1]  = ra2;

    // Read muxes: zero for r0/out-of-range, bypassed write, else array.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd[p]    = '0;
            w_rbusy[p] = 1'b0;
            if ((32'(w_ra[p]) < NREGS)
                && !(ZERO_R0 && (w_ra[p] == reg_addr_t'(REG_ZERO)))) begin
                if (BYPASS && w_wr_legal && (wa3 == w_ra[p])) begin
                    // Retiring producer: forward its data, no longer busy.
                    w_rd[p] = wd3;
                end else begin
                    w_rd[p]    = r_regs[w_ra[p]];
                    w_rbusy[p] = w_busy[w_ra[p]];
                end
            end
        end
    end

    assign rd1    = w_rd[0];
    assign rd2    = w_rd[1];
    assign rbusy1 = w_rbusy[0];
    assign rbusy2 = w_rbusy[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (bypass, no-bypass, 32x12).
module tb_regfile_sb;

    logic clk;
    logic rst_n;

    // Shared stimulus for the 16x16 bypass (a) and no-bypass (b) instances.
    logic [3:0]  ra1, ra2, wa3, sb_addr;
    logic        we3, sb_set, sb_flush;
    logic [15:0] wd3;
    logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        a_rb1, a_rb2, b_rb1, b_rb2;
    logic [15:0] a_bv, b_bv;

    // 32-bit, 12-register instance.
    logic [3:0]  c_ra1, c_ra2, c_wa3, c_sb_addr;
    logic        c_we3, c_sb_set, c_sb_flush;
    logic [31:0] c_wd3, c_rd1, c_rd2;
    logic        c_rb1, c_rb2;
    logic [11:0] c_bv;

    int n_checks;
    int n_fail;

    regfile_sb dut_a (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(a_rd1), .rd2(a_rd2),
        .rbusy1(a_rb1), .rbusy2(a_rb2), .we3(we3), .wa3(wa3), .wd3(wd3),
        .sb_set(sb_set), .sb_addr(sb_addr), .sb_flush(sb_flush), .busy_vec(a_bv)
    );

    regfile_sb #(.BYPASS(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(b_rd1), .rd2(b_rd2),
        .rbusy1(b_rb1), .rbusy2(b_rb2), .we3(we3), .wa3(wa3), .wd3(wd3),
        .sb_set(sb_set), .sb_addr(sb_addr), .sb_flush(sb_flush), .busy_vec(b_bv)
    );

    regfile_sb #(.XLEN(32), .NREGS(12)) dut_c (
        .clk(clk), .rst_n(rst_n), .ra1(c_ra1), .ra2(c_ra2), .rd1(c_rd1), .rd2(c_rd2),
        .rbusy1(c_rb1), .rbusy2(c_rb2), .we3(c_we3), .wa3(c_wa3), .wd3(c_wd3),
        .sb_set(c_sb_set), .sb_addr(c_sb_addr), .sb_flush(c_sb_flush), .busy_vec(c_bv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we3 = 1'b0; wa3 = '0; wd3 = '0; sb_set = 1'b0; sb_addr = '0; sb_flush = 1'b0;
        c_we3 = 1'b0; c_wa3 = '0; c_wd3 = '0; c_sb_set = 1'b0; c_sb_addr = '0; c_sb_flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ra1 = 4'd5; ra2 = 4'd0;
        repeat (2) tick();
        n_checks++;
        if (a_rd1 !== 16'h0 || a_rd2 !== 16'h0) begin
            n_fail++; $display("FAIL reset_rd: rd1=%h rd2=%h expected 0000 0000", a_rd1, a_rd2);
        end
        n_checks++;
        if (a_bv !== 16'h0 || a_rb1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: busy_vec=%h rbusy1=%b expected 0000 0", a_bv, a_rb1);
        end
        @(negedge clk); rst_n = 1'b1;
        tick();
        we3 = 1'b1; wa3 = 4'd3; wd3 = 16'h1234;
        tick();
        we3 = 1'b0; ra1 = 4'd3;
        #1;
        n_checks++;
        if (a_rd1 !== 16'h1234) begin
            n_fail++; $display("FAIL write_r3: rd1=%h expected 1234", a_rd1);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (a_rd1 !== 16'h0 || b_rd1 !== 16'h0) begin
            n_fail++; $display("FAIL async_reset: rd1 a=%h b=%h expected 0000", a_rd1, b_rd1);
        end
        @(negedge clk); rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        ra1 = 4'd0; ra2 = 4'd0;
        we3 = 1'b1; wa3 = 4'd7; wd3 = 16'hBEEF;
        tick();
        we3 = 1'b0; ra1 = 4'd7;
        #1;
        n_checks++;
        if (a_rd1 !== 16'hBEEF || b_rd1 !== 16'hBEEF) begin
            n_fail++; $display("FAIL write_r7: rd1 a=%h b=%h expected beef", a_rd1, b_rd1);
        end
        we3 = 1'b1; wa3 = 4'd0; wd3 = 16'hFFFF; sb_set = 1'b1; sb_addr = 4'd0; ra2 = 4'd0;
        #1;
        n_checks++;
        if (a_rd2 !== 16'h0) begin
            n_fail++; $display("FAIL r0_no_bypass: rd2=%h expected 0000", a_rd2);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (a_rd2 !== 16'h0 || a_bv !== 16'h0 || a_rb2 !== 1'b0) begin
            n_fail++; $display("FAIL r0_zero: rd2=%h busy_vec=%h rbusy2=%b expected 0000 0000 0", a_rd2, a_bv, a_rb2);
        end
    endtask

    task automatic test_same_port();
        ra1 = 4'd7; ra2 = 4'd7;
        #1;
        n_checks++;
        if (a_rd1 !== 16'hBEEF || a_rd2 !== 16'hBEEF) begin
            n_fail++; $display("FAIL same_reg_ports: rd1=%h rd2=%h expected beef beef", a_rd1, a_rd2);
        end
    endtask

    task automatic test_bypass();
        we3 = 1'b1; wa3 = 4'd4; wd3 = 16'h0011;
        tick();
        we3 = 1'b0; sb_set = 1'b1; sb_addr = 4'd4;
        tick();
        sb_set = 1'b0;
        we3 = 1'b1; wa3 = 4'd4; wd3 = 16'h00A5; ra2 = 4'd4;
        #1;
        n_checks++;
        if (a_rd2 !== 16'h00A5 || a_rb2 !== 1'b0) begin
            n_fail++; $display("FAIL bypass_on: rd2=%h rbusy2=%b expected 00a5 0", a_rd2, a_rb2);
        end
        n_checks++;
        if (b_rd2 !== 16'h0011 || b_rb2 !== 1'b1) begin
            n_fail++; $display("FAIL bypass_off: rd2=%h rbusy2=%b expected 0011 1", b_rd2, b_rb2);
        end
        tick();
        we3 = 1'b0;
        #1;
        n_checks++;
        if (b_rd2 !== 16'h00A5 || b_rb2 !== 1'b0 || a_bv !== 16'h0) begin
            n_fail++; $display("FAIL after_write: rd2=%h rbusy2=%b busy_vec=%h expected 00a5 0 0000", b_rd2, b_rb2, a_bv);
        end
    endtask

    task automatic test_priority();
        sb_set = 1'b1; sb_addr = 4'd2;
        tick();
        sb_set = 1'b0;
        n_checks++;
        if (a_bv !== 16'h0004) begin
            n_fail++; $display("FAIL set_r2: busy_vec=%h expected 0004", a_bv);
        end
        we3 = 1'b1; wa3 = 4'd2; wd3 = 16'h2222; sb_set = 1'b1; sb_addr = 4'd2;
        tick();
        sb_set = 1'b0;
        n_checks++;
        if (a_bv !== 16'h0004 || b_bv !== 16'h0004) begin
            n_fail++; $display("FAIL set_wins: busy_vec a=%h b=%h expected 0004", a_bv, b_bv);
        end
        tick();
        we3 = 1'b0;
        n_checks++;
        if (a_bv !== 16'h0000) begin
            n_fail++; $display("FAIL write_clears: busy_vec=%h expected 0000", a_bv);
        end
    endtask

    task automatic test_flush();
        sb_set = 1'b1;
        sb_addr = 4'd1; tick();
        sb_addr = 4'd5; tick();
        sb_addr = 4'd9; tick();
        sb_set = 1'b0;
        n_checks++;
        if (a_bv !== 16'h0222) begin
            n_fail++; $display("FAIL set_multi: busy_vec=%h expected 0222", a_bv);
        end
        sb_flush = 1'b1; sb_set = 1'b1; sb_addr = 4'd3;
        tick();
        idle_inputs();
        n_checks++;
        if (a_bv !== 16'h0008) begin
            n_fail++; $display("FAIL flush_set: busy_vec=%h expected 0008", a_bv);
        end
        ra1 = 4'd7; ra2 = 4'd4;
        #1;
        n_checks++;
        if (a_rd1 !== 16'hBEEF || a_rd2 !== 16'h00A5) begin
            n_fail++; $display("FAIL flush_data: rd1=%h rd2=%h expected beef 00a5", a_rd1, a_rd2);
        end
    endtask

    task automatic test_param();
        c_ra1 = 4'd0; c_ra2 = 4'd0;
        c_we3 = 1'b1; c_wa3 = 4'd11; c_wd3 = 32'hDEADBEEF;
        tick();
        c_we3 = 1'b0; c_ra1 = 4'd11; c_ra2 = 4'd11;
        #1;
        n_checks++;
        if (c_rd1 !== 32'hDEADBEEF || c_rd2 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL wide_r11: rd1=%h rd2=%h expected deadbeef", c_rd1, c_rd2);
        end
        c_we3 = 1'b1; c_wa3 = 4'd13; c_wd3 = 32'h12345678;
        c_sb_set = 1'b1; c_sb_addr = 4'd13;
        tick();
        c_we3 = 1'b0; c_sb_set = 1'b0; c_ra1 = 4'd13;
        #1;
        n_checks++;
        if (c_rd1 !== 32'h0 || c_rb1 !== 1'b0 || c_bv !== 12'h000) begin
            n_fail++; $display("FAIL out_of_range: rd1=%h rbusy1=%b busy_vec=%h expected 0 0 000", c_rd1, c_rb1, c_bv);
        end
        n_checks++;
        if (c_rd2 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL oor_no_alias: rd2=%h expected deadbeef", c_rd2);
        end
        c_sb_set = 1'b1; c_sb_addr = 4'd11;
        tick();
        c_sb_set = 1'b0;
        n_checks++;
        if (c_bv !== 12'h800 || c_rb2 !== 1'b1) begin
            n_fail++; $display("FAIL top_reg_busy: busy_vec=%h rbusy2=%b expected 800 1", c_bv, c_rb2);
        end
    endtask

    // Global bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        ra1 = '0; ra2 = '0; c_ra1 = '0; c_ra2 = '0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_same_port();
        test_bypass();
        test_priority();
        test_flush();
        test_param();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
